// File: rtl/tlc_request_timer_if.sv
// Controller-facing signals of the request timer: count clear/value and
// the conditioned farm-road request with its farm-light feedback.
interface tlc_request_timer_if #(
  parameter int CNT_W = 31
);
  logic             RstCount;
  logic [1:0]       farmSignal;
  logic [CNT_W-1:0] Count;
  logic             farmSensor;

  modport master (output RstCount, farmSignal, input Count, farmSensor);
  modport slave  (input RstCount, farmSignal, output Count, farmSensor);
endinterface

// File: rtl/tlc_request_timer.sv
// Interval timer and farm-road request conditioner for the traffic-light
// controller: sync -> debounce -> latch, released once the request is served.
module tlc_request_timer #(
  parameter int CNT_W           = 31,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               farmSensorRaw,
  tlc_request_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PENDING, SERVING} req_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       GREEN   = 2'b11;

  logic [CNT_W-1:0] cnt;
  logic             sync1, sync2;
  logic             stable, stable_d;
  logic [DB_W-1:0]  dbCnt;
  logic             rise;
  logic             req;
  req_state_t       state, state_nxt;
  logic             req_nxt;

  always_ff @(posedge Clk) begin
    if (Rst)                 cnt <= '0;
    else if (bus.RstCount)   cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      dbCnt    <= '0;
    end else begin
      sync1    <= farmSensorRaw;
      sync2    <= sync1;
      stable_d <= stable;
      // A single cycle agreeing with stable restarts qualification.
      if (sync2 == stable) begin
        dbCnt <= '0;
      end else if (dbCnt == DB_LAST) begin
        stable <= sync2;
        dbCnt  <= '0;
      end else begin
        dbCnt <= dbCnt + 1'b1;
      end
    end
  end

  assign rise = stable & ~stable_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      req   <= 1'b0;
    end else begin
      state <= state_nxt;
      req   <= req_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = 1'b0;
    case (state)
      IDLE:    if (rise) state_nxt = PENDING;
      PENDING: if (bus.farmSignal == GREEN) state_nxt = SERVING;
      SERVING: if (bus.farmSignal != GREEN) state_nxt = stable ? PENDING : IDLE;
      default: state_nxt = IDLE;
    endcase
    // While served, the request tracks the vehicle so green can end early.
    case (state_nxt)
      PENDING: req_nxt = 1'b1;
      SERVING: req_nxt = stable;
      default: req_nxt = 1'b0;
    endcase
  end

  assign bus.Count      = cnt;
  assign bus.farmSensor = req;
endmodule

// File: tb/tb_tlc_request_timer.sv
// Directed bench for tlc_request_timer with a per-cycle reference model.
module tb_tlc_request_timer;
  localparam int CW   = 4;
  localparam int DB   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic Clk = 1'b0;
  logic Rst;
  logic raw;
  int   nvec = 0;
  int   nmis = 0;

  tlc_request_timer_if #(.CNT_W(CW)) bus ();

  tlc_request_timer #(.CNT_W(CW), .DEBOUNCE_CYCLES(DB), .DB_W(3)) dut (
    .Clk(Clk), .Rst(Rst), .farmSensorRaw(raw), .bus(bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: samples seen through a 2-cycle delay are accepted once
  // the latest DB of them all disagree with the accepted level. A request is
  // remembered from an accepted arrival until served by green; leaving green
  // with the vehicle still present re-arms it.
  int m_cnt;
  bit m_s1, m_s2, m_stab, m_stab_d;
  bit hist [DB-1];
  bit waiting, served, m_fs, seen;

  always @(posedge Clk) begin
    automatic bit all_diff;
    automatic bit w, s;
    if (Rst) begin
      m_cnt <= 0; m_s1 <= 0; m_s2 <= 0; m_stab <= 0; m_stab_d <= 0;
      for (int i = 0; i < DB-1; i++) hist[i] <= 0;
      waiting <= 0; served <= 0; m_fs <= 0; seen <= 1;
    end else begin
      m_cnt <= bus.RstCount ? 0 : (m_cnt < CMAX ? m_cnt + 1 : m_cnt);
      m_s1  <= raw;
      m_s2  <= m_s1;
      all_diff = (m_s2 != m_stab);
      for (int i = 0; i < DB-1; i++) if (hist[i] == m_stab) all_diff = 0;
      for (int i = DB-2; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= m_s2;
      if (all_diff) m_stab <= m_s2;
      m_stab_d <= m_stab;
      w = waiting; s = served;
      if (!waiting && !served) w = m_stab && !m_stab_d;
      else if (waiting && bus.farmSignal == 2'b11) begin w = 0; s = 1; end
      else if (served && bus.farmSignal != 2'b11) begin w = m_stab; s = 0; end
      waiting <= w;
      served  <= s;
      m_fs    <= w ? 1'b1 : (s ? m_stab : 1'b0);
    end
  end

  always @(posedge Clk) begin
    #1;
    if (seen) begin
      chk("model_Count", int'(bus.Count), m_cnt);
      chk("model_farmSensor", int'(bus.farmSensor), int'(m_fs));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge Clk); #2; end
  endtask

  initial begin
    Rst = 1; raw = 1; bus.RstCount = 0; bus.farmSignal = 2'b01;
    // reset held two edges
    step(); chk("rst_Count0", int'(bus.Count), 0); chk("rst_fs0", int'(bus.farmSensor), 0);
    step(); chk("rst_Count1", int'(bus.Count), 0); chk("rst_fs1", int'(bus.farmSensor), 0);
    Rst = 0; raw = 0;
    step(); chk("rel_Count", int'(bus.Count), 1);
    bus.farmSignal = 2'b11;
    step(); chk("idle_green_fs", int'(bus.farmSensor), 0);
    bus.farmSignal = 2'b01;
    step(8); chk("cnt10", int'(bus.Count), 10);
    bus.RstCount = 1; step(); chk("clr_pulse", int'(bus.Count), 0);
    bus.RstCount = 0; step(); chk("clr_p1", int'(bus.Count), 1);
    step(); chk("clr_p2", int'(bus.Count), 2);
    bus.RstCount = 1;
    for (int i = 0; i < 3; i++) begin step(); chk("clr_hold", int'(bus.Count), 0); end
    bus.RstCount = 0;

    // glitch rejection
    raw = 1; step(3); raw = 0; step(8);
    chk("glitch3", int'(bus.farmSensor), 0);
    raw = 1; step(3); raw = 0; step(1); raw = 1; step(3); raw = 0; step(8);
    chk("glitch3_1_3", int'(bus.farmSensor), 0);

    // latch and serve
    raw = 1; step(6); raw = 0;
    chk("latch_e5", int'(bus.farmSensor), 0);
    step(); chk("latch_e6", int'(bus.farmSensor), 1);
    step(100); chk("latch_hold", int'(bus.farmSensor), 1);
    bus.farmSignal = 2'b11; step(); chk("serve_gone", int'(bus.farmSensor), 0);
    bus.farmSignal = 2'b10; step(); chk("serve_yel", int'(bus.farmSensor), 0);
    bus.farmSignal = 2'b01; step(); chk("serve_idle", int'(bus.farmSensor), 0);

    // re-request with vehicle present through green
    raw = 1; step(7); chk("rereq_latch", int'(bus.farmSensor), 1);
    bus.farmSignal = 2'b11; step(); chk("rereq_green", int'(bus.farmSensor), 1);
    step(5); chk("rereq_green5", int'(bus.farmSensor), 1);
    bus.farmSignal = 2'b10; step(); chk("rereq_pend", int'(bus.farmSensor), 1);
    bus.farmSignal = 2'b01; raw = 0; step(20); chk("rereq_held", int'(bus.farmSensor), 1);
    bus.farmSignal = 2'b11; step(); bus.farmSignal = 2'b01; step();
    chk("rereq_done", int'(bus.farmSensor), 0);

    // saturation
    bus.RstCount = 1; step(); bus.RstCount = 0;
    step(15); chk("sat_reach", int'(bus.Count), 15);
    for (int i = 0; i < 20; i++) begin step(); chk("sat_hold", int'(bus.Count), 15); end

    // reset while pending
    raw = 1; step(7); chk("mid_pend", int'(bus.farmSensor), 1);
    raw = 0; Rst = 1; step();
    chk("mid_rst_fs", int'(bus.farmSensor), 0); chk("mid_rst_cnt", int'(bus.Count), 0);
    Rst = 0; step(10); chk("mid_after", int'(bus.farmSensor), 0);
    bus.farmSignal = 2'b11; step(); chk("mid_idle_green", int'(bus.farmSensor), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
